// File: rtl/if_prefetch.sv
// -----------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch unit with a DEPTH-entry prefetch queue. Sequential fetches
// go out on a strobe/ack bus and the returned words are queued with their PCs.
// Decode takes them over a valid/ready handshake. A redirect from execute
// flushes the queue and restarts fetching at the target.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   o_imem_stb      fetch request strobe
//   o_iaddr         fetch address (the current fetch PC)
//   i_inst          instruction word, sampled when o_imem_stb && i_imem_ack
//   i_imem_ack      completes the current request in the same cycle
//   i_redirect      one-cycle flush pulse from execute
//   i_redirect_pc   redirect target (bit 0 is dropped)
//   o_valid         queue head holds an instruction
//   i_ready         decode accepts the head this cycle
//   o_pc, o_instr   head PC / instruction (fetch PC / NOP_INSTR when empty)
//   o_count         queue occupancy
// -----------------------------------------------------------------------------
module if_prefetch #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     o_imem_stb,
  output logic [31:0]              o_iaddr,
  input  logic [31:0]              i_inst,
  input  logic                     i_imem_ack,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_instr,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic [31:0]   pc_mem_r  [DEPTH];
  logic [31:0]   ins_mem_r [DEPTH];

  logic stb_s;
  logic valid_s;
  logic push_s;
  logic pop_s;

  // Handshake qualifiers; redirect masks both push and pop.
  always_comb begin
    stb_s   = rst_n && !i_redirect && (count_r < DEPTH_C);
    valid_s = (count_r != {CW{1'b0}});
    push_s  = stb_s && i_imem_ack;
    pop_s   = valid_s && i_ready && !i_redirect;
  end

  // Output drive: head entry when valid, fetch PC / NOP filler when empty.
  always_comb begin
    o_imem_stb = stb_s;
    o_iaddr    = fetch_pc_r;
    o_valid    = valid_s;
    o_count    = count_r;
    if (valid_s) begin
      o_pc    = pc_mem_r[rd_ptr_r];
      o_instr = ins_mem_r[rd_ptr_r];
    end else begin
      o_pc    = fetch_pc_r;
      o_instr = NOP_INSTR;
    end
  end

  // Fetch PC, queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= PC_RESET;
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else if (i_redirect) begin
      // Flush wins over any same-cycle ack or pop.
      fetch_pc_r <= {i_redirect_pc[31:1], 1'b0};
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
        wr_ptr_r   <= wr_ptr_r + AW'(1);
      end else begin
        fetch_pc_r <= fetch_pc_r;
        wr_ptr_r   <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage: {pc, instr} written at the write pointer on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]  <= 32'h0000_0000;
        ins_mem_r[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]  <= fetch_pc_r;
      ins_mem_r[wr_ptr_r] <= i_inst;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]  <= pc_mem_r[i];
        ins_mem_r[i] <= ins_mem_r[i];
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch
// Self-checking bench for if_prefetch (DEPTH=4). A directed vector table covers
// reset fetch, fill-to-full, drain and a redirect to 0x101. Then hand sequences
// and random traffic are checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_if_prefetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        o_imem_stb;
  logic [31:0] o_iaddr;
  logic [31:0] i_inst;
  logic        i_imem_ack;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [2:0]  o_count;

  int checks;
  int errors;

  if_prefetch #(.PC_RESET(32'h0000_0000), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .o_imem_stb(o_imem_stb), .o_iaddr(o_iaddr),
    .i_inst(i_inst), .i_imem_ack(i_imem_ack), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_instr(o_instr), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (~a) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ack;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        stb;
    logic [31:0] iaddr;
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vt[16];

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;

  task automatic model_step(input logic ack, input logic ready,
                            input logic redir, input logic [31:0] rpc);
    logic        e_stb;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    ent_t        ne;
    @(negedge clk);
    i_imem_ack    = ack;
    i_ready       = ready;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_inst        = mem_word(m_fpc);
    #1;
    e_stb   = !redir && (mq.size() < DEPTH);
    e_valid = (mq.size() > 0);
    e_pc    = e_valid ? mq[0].pc  : m_fpc;
    e_ins   = e_valid ? mq[0].ins : NOP;
    chk("m_stb",   32'(o_imem_stb), 32'(e_stb));
    chk("m_iaddr", o_iaddr, m_fpc);
    chk("m_valid", 32'(o_valid), 32'(e_valid));
    chk("m_pc",    o_pc, e_pc);
    chk("m_instr", o_instr, e_ins);
    chk("m_count", 32'(o_count), 32'(mq.size()));
    @(posedge clk);
    if (redir) begin
      mq.delete();
      m_fpc = rpc & ~32'h1;
    end else begin
      if (e_valid && ready) void'(mq.pop_front());
      if (e_stb && ack) begin
        ne.pc  = m_fpc;
        ne.ins = mem_word(m_fpc);
        mq.push_back(ne);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    i_imem_ack = 1'b0;
    i_ready = 1'b0;
    i_redirect = 1'b0;
    i_redirect_pc = 32'h0;
    i_inst = 32'h0;

    //                ack  rdy  rdr  rpc            stb  iaddr          vld  pc             cnt
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 3'd0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000, 3'd1};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004, 3'd1};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008, 3'd1};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C, 3'd1};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0014, 1'b1, 32'h0000_000C, 3'd2};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0018, 1'b1, 32'h0000_000C, 3'd3};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_001C, 1'b1, 32'h0000_000C, 3'd4};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_001C, 1'b1, 32'h0000_000C, 3'd4};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_001C, 1'b1, 32'h0000_0010, 3'd3};
    vt[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0020, 1'b1, 32'h0000_0014, 3'd3};
    vt[11] = '{1'b1, 1'b0, 1'b1, 32'h0000_0101, 1'b0, 32'h0000_0024, 1'b1, 32'h0000_0018, 3'd3};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100, 3'd0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b0, 32'h0000_0100, 3'd0};
    vt[14] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100, 3'd1};
    vt[15] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b0, 32'h0000_0104, 3'd0};

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stb",   32'(o_imem_stb), 32'h0);
    chk("rst_iaddr", o_iaddr, 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_pc",    o_pc, 32'h0);
    chk("rst_instr", o_instr, NOP);
    chk("rst_count", 32'(o_count), 32'h0);

    // Release with ack low: the first clock with rst_n=1 cannot push.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_stb", 32'(o_imem_stb), 32'h1);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      i_imem_ack    = vt[i].ack;
      i_ready       = vt[i].ready;
      i_redirect    = vt[i].redir;
      i_redirect_pc = vt[i].rpc;
      i_inst        = mem_word(vt[i].iaddr);
      #1;
      chk($sformatf("v%0d_stb", i),   32'(o_imem_stb), 32'(vt[i].stb));
      chk($sformatf("v%0d_iaddr", i), o_iaddr, vt[i].iaddr);
      chk($sformatf("v%0d_valid", i), 32'(o_valid), 32'(vt[i].valid));
      chk($sformatf("v%0d_pc", i),    o_pc, vt[i].pc);
      chk($sformatf("v%0d_instr", i), o_instr, vt[i].valid ? mem_word(vt[i].pc) : NOP);
      chk($sformatf("v%0d_count", i), 32'(o_count), 32'(vt[i].cnt));
    end

    // Hand over to the model: queue empty, fetch PC at 0x104.
    mq.delete();
    m_fpc = 32'h0000_0104;

    // Wait states: build two entries, then withhold ack for 3 cycles.
    model_step(1'b1, 1'b0, 1'b0, 32'h0);
    model_step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) model_step(1'b0, 1'b1, 1'b0, 32'h0);
    model_step(1'b1, 1'b1, 1'b0, 32'h0);

    // Push and pop together at count 2; pointers wrap several times.
    model_step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (10) model_step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect near the top of the address space with bit 1 set, then wrap.
    model_step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF7);
    repeat (4) model_step(1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      model_step(($urandom_range(3) != 0), ($urandom_range(2) != 0),
                 ($urandom_range(19) == 0), $urandom);
    end

    // Fill the queue, then reset asynchronously between edges.
    repeat (6) model_step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_count", 32'(o_count), 32'(mq.size()));
    @(negedge clk);
    i_imem_ack = 1'b0;
    i_ready    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_stb",   32'(o_imem_stb), 32'h0);
    chk("mrst_iaddr", o_iaddr, 32'h0);
    chk("mrst_valid", 32'(o_valid), 32'h0);
    chk("mrst_pc",    o_pc, 32'h0);
    chk("mrst_instr", o_instr, NOP);
    chk("mrst_count", 32'(o_count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_fpc = 32'h0;
    repeat (6) model_step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
